dct_transpose_buf: RTL and testbench
====================================

Name: dct_transpose_buf

Overview:
- 8x8 transpose buffer between the first (row) 1-D DCT pass and the second (column) 1-D DCT pass.
- Accepts one 8-sample row per valid cycle from the row-DCT stage and emits the same block column by column, with the same valid/sob/eob/sof framing.
- Ping-pong storage (two 8x8 banks) sustains full-rate continuous blocks with no backpressure.

Parameters:
- W, 16, signed sample width of each coefficient in and out.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  in_data holds one row this cycle.
- in_data  in  8xW signed  row samples; element c = column c.
- in_sob  in  1  first row (row 0) of a block; qualified by in_valid.
- in_eob  in  1  last row (row 7) of a block; qualified by in_valid.
- in_sof  in  1  block is first of frame; sampled with in_sob.
- out_valid  out  1  out_data holds one column.
- out_data  out  8xW signed  column samples; element r = row r.
- out_sob  out  1  column 0 of a block.
- out_eob  out  1  column 7 of a block.
- out_sof  out  1  asserted with out_sob when the block's in_sof was set.

Behaviour:
- Reset (rst_n low at clk edge): out_valid, out_sob, out_eob, out_sof, out_data = 0. Row counter = 0, write bank = 0, read idle, stored sof flags cleared. Bank memory contents are not cleared. A reset mid-block discards the partial block and any in-progress readout.
- Write side:
  - Each in_valid cycle writes in_data into the current write bank at row = row counter, then increments the row counter.
  - in_valid with in_sob forces the write to row 0, restarting the block; any partial block in that bank is discarded.
  - in_sof is latched per bank on the in_sob row.
  - Writing row 7 completes the bank: the write bank toggles, the row counter wraps to 0, and readout of the completed bank is scheduled.
  - in_eob is not used for counting; it is checked only under the optional feature.
  - in_valid low: no state change.
- Read side:
  - Latency: column 0 appears on the outputs 2 cycles after the row-7 input cycle (row 7 in cycle t → col 0 in cycle t+2). Columns 1..7 follow on consecutive cycles (t+3 .. t+9).
  - out_data[r] for column c equals in_data[c] of row r.
  - out_sob = 1 on column 0 only; out_eob = 1 on column 7 only; out_sof = latched bank sof on column 0 only.
  - Outside a readout, out_valid = 0 and the sob/eob/sof outputs are 0. out_data holds its last value.
- Throughput: a bank fills in ≥8 cycles and drains in exactly 8, so readout never overlaps a refill of the same bank.
  - Back-to-back blocks give gapless output: block A col7 at t+9, block B col0 at t+10.
  - Readout of one bank and writing of the other proceed simultaneously without interference.
- Gaps (in_valid low mid-block) only delay block completion. Output columns of a block are always contiguous.

Optional Feature:
- Macro: TRANSPOSE_PROTO_CHECK_EN.
- Defined: adds output port proto_err (1 bit, reset 0, sticky until reset). It is set the cycle after any of:
  - in_valid with in_eob while the row counter ≠ 7;
  - in_valid on row 7 without in_eob;
  - in_valid with in_sob while the row counter ≠ 0 (the restart still happens).
- Not defined: port absent, no checking logic. Datapath behaviour is identical either way.

Test Plan:
- Single block: 8 consecutive rows, in_data[c] = 16*r + c, sob on row 0, eob on row 7, sof = 1 → out_valid for 8 cycles starting 2 cycles after row 7; column c has out_data[r] = 16*r + c; sob+sof on col 0, eob on col 7.
- Three back-to-back blocks with distinct patterns (bases 0, 0x100, 0x200), sof only on the first → 24 contiguous out_valid cycles, correct transposes, out_sof only on the first block's col 0.
- Gapped input: in_valid low for 3 cycles between rows 2 and 3 → output identical to the single-block case, shifted 3 cycles later, columns still contiguous.
- Restart: 4 rows, then in_sob again followed by a full 8-row block → exactly one 8-column output block containing only the second block's data.
- Negative values: rows filled with -32768 and 32767 alternating by column → exact signed transpose, no sign corruption.
- Reset mid-readout (rst_n low at column 3 for 1 cycle) → outputs 0 the next cycle, no remaining columns; the next full block transposes correctly. With TRANSPOSE_PROTO_CHECK_EN: in_eob on row 5 → proto_err = 1 and held until reset.

Source files
------------

// File: rtl/dct_transpose_buf.sv
// dct_transpose_buf: ping-pong 8x8 transpose buffer, rows in / columns out.
// Define TRANSPOSE_PROTO_CHECK_EN to add the sticky proto_err framing checker.
module dct_transpose_buf #(
    parameter int W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [7:0][W-1:0]   in_data,
    input  logic                in_sob,
    input  logic                in_eob,
    input  logic                in_sof,
    output logic                out_valid,
    output logic [7:0][W-1:0]   out_data,
    output logic                out_sob,
    output logic                out_eob,
`ifdef TRANSPOSE_PROTO_CHECK_EN
    output logic                proto_err,
`endif
    output logic                out_sof
);
    logic [7:0][W-1:0] mem [2][8];
    logic [7:0][W-1:0] col_data;
    logic [2:0] row_cnt, wr_row, rd_col;
    logic       wr_bank, rd_bank, rd_active, done;
    logic [1:0] sof_q;

    assign wr_row = in_sob ? 3'd0 : row_cnt;
    assign done   = in_valid && wr_row == 3'd7;

    always_ff @(posedge clk)
        if (in_valid) mem[wr_bank][wr_row] <= in_data;

    always_comb begin
        col_data = '0;
        for (int r = 0; r < 8; r++) col_data[r] = mem[rd_bank][r][rd_col];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_cnt   <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            rd_col    <= '0;
            rd_active <= 1'b0;
            sof_q     <= '0;
            out_valid <= 1'b0;
            out_sob   <= 1'b0;
            out_eob   <= 1'b0;
            out_sof   <= 1'b0;
            out_data  <= '0;
        end else begin
            if (in_valid) begin
                row_cnt <= wr_row + 3'd1;
                if (in_sob) sof_q[wr_bank] <= in_sof;
                if (wr_row == 3'd7) wr_bank <= ~wr_bank;
            end
            out_valid <= rd_active;
            out_sob   <= rd_active && rd_col == 3'd0;
            out_eob   <= rd_active && rd_col == 3'd7;
            out_sof   <= rd_active && rd_col == 3'd0 && sof_q[rd_bank];
            if (rd_active) out_data <= col_data;
            // a newly completed bank only ever lands on the last column of the previous readout
            if (done) begin
                rd_active <= 1'b1;
                rd_col    <= '0;
                rd_bank   <= wr_bank;
            end else if (rd_active) begin
                rd_col    <= rd_col + 3'd1;
                rd_active <= rd_col != 3'd7;
            end
        end
    end

`ifdef TRANSPOSE_PROTO_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            proto_err <= 1'b0;
        else if (in_valid && ((in_eob && wr_row != 3'd7) || (wr_row == 3'd7 && !in_eob) ||
                              (in_sob && row_cnt != 3'd0)))
            proto_err <= 1'b1;
    end
`else
    logic unused_eob;
    assign unused_eob = in_eob;
`endif
endmodule

// File: tb/tb_dct_transpose_buf.sv
// tb_dct_transpose_buf: scoreboard bench; expected columns queued when row 7 is driven.
module tb_dct_transpose_buf;
    localparam int W = 16;
    logic clk = 1'b0, rst_n = 1'b0;
    logic in_valid = 1'b0, in_sob = 1'b0, in_eob = 1'b0, in_sof = 1'b0;
    logic [7:0][W-1:0] in_data = '0;
    logic [7:0][W-1:0] out_data;
    logic out_valid, out_sob, out_eob, out_sof;
`ifdef TRANSPOSE_PROTO_CHECK_EN
    logic proto_err;
`endif

    dct_transpose_buf #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_sob(in_sob), .in_eob(in_eob), .in_sof(in_sof),
        .out_valid(out_valid), .out_data(out_data), .out_sob(out_sob),
        .out_eob(out_eob),
`ifdef TRANSPOSE_PROTO_CHECK_EN
        .proto_err(proto_err),
`endif
        .out_sof(out_sof)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0][W-1:0] d;
        logic sob, eob, sof;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int cyc = 0, tests = 0, fails = 0;
    logic [W-1:0] mblk [8][8];
    logic [2:0] mrow = '0;
    logic msof = 1'b0;

    // one clock; outputs sampled on the falling edge and checked against the scoreboard
    task automatic step();
        exp_t e;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (out_valid) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL spurious_col cyc=%0d got data=%h sob=%b eob=%b sof=%b, want no output",
                         cyc, out_data, out_sob, out_eob, out_sof);
            end else begin
                e = exp_q.pop_front();
                if ({out_data, out_sob, out_eob, out_sof} !== {e.d, e.sob, e.eob, e.sof} || cyc != e.cyc) begin
                    fails++;
                    $display("FAIL column cyc=%0d got data=%h sob=%b eob=%b sof=%b, want cyc=%0d data=%h sob=%b eob=%b sof=%b",
                             cyc, out_data, out_sob, out_eob, out_sof, e.cyc, e.d, e.sob, e.eob, e.sof);
                end
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            tests++;
            fails++;
            e = exp_q.pop_front();
            $display("FAIL missing_col cyc=%0d got out_valid=0, want column due at cyc=%0d", cyc, e.cyc);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0][W-1:0] d, input logic s, input logic e, input logic f);
        logic [2:0] r;
        exp_t ex;
        in_valid = v; in_data = d; in_sob = s; in_eob = e; in_sof = f;
        if (v) begin
            r = s ? 3'd0 : mrow;
            for (int c = 0; c < 8; c++) mblk[r][c] = d[c];
            if (s) msof = f;
            if (r == 3'd7)
                for (int c = 0; c < 8; c++) begin
                    for (int k = 0; k < 8; k++) ex.d[k] = mblk[k][c];
                    ex.sob = c == 0;
                    ex.eob = c == 7;
                    ex.sof = c == 0 && msof;
                    ex.cyc = cyc + 2 + c;
                    exp_q.push_back(ex);
                end
            mrow = r + 3'd1;
        end
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [7:0][W-1:0] row_of(input int base, input int r);
        logic [7:0][W-1:0] d;
        for (int c = 0; c < 8; c++) d[c] = W'(base + 16 * r + c);
        return d;
    endfunction

    task automatic send_block(input int base, input logic f);
        for (int r = 0; r < 8; r++) drive(1'b1, row_of(base, r), r == 0, r == 7, f);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) idle(1);
        idle(4);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_drain got %0d columns outstanding, want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        tests++;
        if ({out_valid, out_sob, out_eob, out_sof, out_data} !== '0) begin
            fails++;
            $display("FAIL reset got valid=%b sob=%b eob=%b sof=%b data=%h, want all 0",
                     out_valid, out_sob, out_eob, out_sof, out_data);
        end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_single();
        send_block(0, 1'b1);
        drain("single");
    endtask

    task automatic test_back_to_back();
        send_block(0, 1'b1);
        send_block('h100, 1'b0);
        send_block('h200, 1'b0);
        drain("back_to_back");
    endtask

    task automatic test_gap();
        for (int r = 0; r < 3; r++) drive(1'b1, row_of(0, r), r == 0, 1'b0, 1'b1);
        idle(3);
        for (int r = 3; r < 8; r++) drive(1'b1, row_of(0, r), 1'b0, r == 7, 1'b1);
        drain("gap");
    endtask

    task automatic test_restart();
        for (int r = 0; r < 4; r++) drive(1'b1, row_of('h300, r), r == 0, 1'b0, 1'b1);
        send_block('h400, 1'b0);
        drain("restart");
    endtask

    task automatic test_negative();
        logic [7:0][W-1:0] d;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) d[c] = ((c + r) % 2 != 0) ? 16'h7fff : 16'h8000;
            drive(1'b1, d, r == 0, r == 7, 1'b0);
        end
        drain("negative");
    endtask

    task automatic test_reset_mid();
        send_block('h500, 1'b1);
        for (int i = 0; i < 20 && exp_q.size() > 4; i++) idle(1);
        rst_n = 1'b0;
        exp_q.delete();
        mrow = '0;
        msof = 1'b0;
        step();
        tests++;
        if ({out_valid, out_sob, out_eob, out_sof, out_data} !== '0) begin
            fails++;
            $display("FAIL reset_mid got valid=%b sob=%b eob=%b sof=%b data=%h, want all 0",
                     out_valid, out_sob, out_eob, out_sof, out_data);
        end
        rst_n = 1'b1;
        idle(12);
        send_block('h600, 1'b1);
        drain("reset_mid");
    endtask

`ifdef TRANSPOSE_PROTO_CHECK_EN
    task automatic test_proto();
        tests++;
        if (proto_err !== 1'b0) begin
            fails++;
            $display("FAIL proto_clean got proto_err=%b, want 0", proto_err);
        end
        for (int r = 0; r < 5; r++) drive(1'b1, row_of('h700, r), r == 0, 1'b0, 1'b0);
        drive(1'b1, row_of('h700, 5), 1'b0, 1'b1, 1'b0);
        tests++;
        if (proto_err !== 1'b1) begin
            fails++;
            $display("FAIL proto_set got proto_err=%b, want 1", proto_err);
        end
        idle(5);
        tests++;
        if (proto_err !== 1'b1) begin
            fails++;
            $display("FAIL proto_sticky got proto_err=%b, want 1", proto_err);
        end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_gap();
        test_restart();
        test_negative();
        test_reset_mid();
`ifdef TRANSPOSE_PROTO_CHECK_EN
        test_proto();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
